// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO drain arbiter: FSM state encoding and the
// beat counter width helper.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  // Wide enough to hold BURST_LEN itself.
  function automatic int beat_cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// FIFO read sides plus the outgoing beat stream of the drain arbiter.
// master = arbiter view, slave = FIFO/downstream view.
interface fifo_drain_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]            ch_empty_i;
  logic [NUM_CH-1:0]            ch_pop_o;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i;
  logic [DATA_WIDTH-1:0]        m_data_o;
  logic                         m_valid_o;
  logic                         m_ready_i;
  logic [CH_W-1:0]              m_ch_o;
  logic                         m_last_o;

  modport master (
    input  ch_empty_i, ch_data_i, m_ready_i,
    output ch_pop_o, m_data_o, m_valid_o, m_ch_o, m_last_o
  );

  modport slave (
    output ch_empty_i, ch_data_i, m_ready_i,
    input  ch_pop_o, m_data_o, m_valid_o, m_ch_o, m_last_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i, wrapping,
// so the previously granted channel has the lowest priority.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic              gnt_valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_CH);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains several FIFO read sides onto one valid/ready beat stream, granting
// channels round-robin for bursts of up to BURST_LEN beats.
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fifo_drain_arbiter_if.master bus,
  output logic                 busy_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = beat_cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_e                state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [NUM_CH-1:0]     grant_oh_q, grant_oh_d;
  logic [CH_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [CH_W-1:0]       m_ch_q, m_ch_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [NUM_CH-1:0]     ch_pop;

  logic [NUM_CH-1:0]     arb_gnt;
  logic [CH_W-1:0]       arb_idx;
  logic                  arb_valid;
  logic [DATA_WIDTH-1:0] ch_word [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_word[k] = bus.ch_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(CH_W)) u_rr (
    .req_i       (~bus.ch_empty_i),
    .ptr_i       (last_grant_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    m_data_d     = m_data_q;
    m_ch_d       = m_ch_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    ch_pop       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d      = arb_idx;
          grant_oh_d   = arb_gnt;
          last_grant_d = arb_idx;
          beat_cnt_d   = '0;
          state_d      = ST_POP;
        end
      end
      ST_POP: begin
        ch_pop  = grant_oh_q;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // The popped word is on ch_data_i now; an empty flag here means it was the last.
        m_data_d  = ch_word[grant_q];
        m_ch_d    = grant_q;
        m_valid_d = 1'b1;
        m_last_d  = (beat_cnt_q == LAST_CNT) | (|(bus.ch_empty_i & grant_oh_q));
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (m_valid_q && bus.m_ready_i) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            state_d = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            state_d    = ST_POP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
    if (rst_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      beat_cnt_q   <= '0;
      m_data_q     <= '0;
      m_ch_q       <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      m_data_q     <= m_data_d;
      m_ch_q       <= m_ch_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
    end
  end

  assign bus.ch_pop_o  = ch_pop;
  assign bus.m_data_o  = m_data_q;
  assign bus.m_ch_o    = m_ch_q;
  assign bus.m_valid_o = m_valid_q;
  assign bus.m_last_o  = m_last_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: behavioural FIFOs with one-cycle
// read latency feed the DUT; accepted beats are logged and compared.
module tb_fifo_drain_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int BL     = 8;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  fifo_drain_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();

  fifo_drain_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .bus    (bus),
    .busy_o (busy)
  );

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic [DW-1:0] mem [NUM_CH][DEPTH];
  logic [DW-1:0] rd_data [NUM_CH] = '{default: '0};
  int            wr_ptr  [NUM_CH] = '{default: 0};
  int            rd_ptr  [NUM_CH] = '{default: 0};
  int            pop_cnt [NUM_CH] = '{default: 0};
  beat_t         beat_log [$];
  int            checks   = 0;
  int            failures = 0;

  function automatic logic [DW-1:0] word(input int ch, input int idx);
    return {8'hA0, 8'(ch), 16'(idx)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural FIFOs: pop at an edge presents the word in the next cycle.
  always_comb begin
    bus.ch_empty_i = '0;
    bus.ch_data_i  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      bus.ch_empty_i[k]         = (wr_ptr[k] == rd_ptr[k]);
      bus.ch_data_i[k*DW +: DW] = rd_data[k];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.ch_pop_o[k] && (wr_ptr[k] != rd_ptr[k])) begin
        rd_data[k] <= mem[k][rd_ptr[k]];
        rd_ptr[k]  <= rd_ptr[k] + 1;
      end
    end
  end

  // Inputs change just after posedge, so negedge values decide the next edge.
  always @(negedge clk) begin
    if (!rst_i) begin
      check("pop_onehot0", 64'($onehot0(bus.ch_pop_o)), 64'd1);
      check("pop_on_empty", 64'(bus.ch_pop_o & bus.ch_empty_i), 64'd0);
      for (int k = 0; k < NUM_CH; k++) if (bus.ch_pop_o[k]) pop_cnt[k]++;
      if (bus.m_valid_o && bus.m_ready_i)
        beat_log.push_back({bus.m_ch_o, bus.m_data_o, bus.m_last_o});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[ch][wr_ptr[ch]] = word(ch, first + i);
      wr_ptr[ch]++;
    end
  endtask

  function automatic int total_pops();
    int s = 0;
    for (int k = 0; k < NUM_CH; k++) s += pop_cnt[k];
    return s;
  endfunction

  task automatic wait_beats(input int n, input int budget, input string tag);
    int cnt = 0;
    while (beat_log.size() < n && cnt < budget) begin
      tick();
      cnt++;
    end
    check(tag, 64'(beat_log.size() >= n), 64'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int cnt = 0;
    while (!bus.m_valid_o && cnt < budget) begin
      tick();
      cnt++;
    end
    check(tag, 64'(bus.m_valid_o), 64'd1);
  endtask

  task automatic check_beat(input string tag, input int n, input int ch, input logic [DW-1:0] data,
                            input logic last);
    if (n < beat_log.size())
      check(tag, 64'(beat_log[n]), 64'({2'(ch), data, last}));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_valid"}, 64'(bus.m_valid_o), 64'd0);
    check({tag, "_last"}, 64'(bus.m_last_o), 64'd0);
    check({tag, "_data"}, 64'(bus.m_data_o), 64'd0);
    check({tag, "_ch"}, 64'(bus.m_ch_o), 64'd0);
    check({tag, "_pop"}, 64'(bus.ch_pop_o), 64'd0);
  endtask

  initial begin
    int n;
    int pops_before;
    bus.m_ready_i = 1'b1;

    // Reset values.
    tick();
    tick();
    check_idle_outputs("reset");
    rst_i = 1'b0;

    // Single word on ch2: pop once, beat valid three cycles later.
    tick();
    push(2, 0, 1);
    tick();
    check("t1_pop", 64'(bus.ch_pop_o), 64'b0100);
    check("t1_valid_c1", 64'(bus.m_valid_o), 64'd0);
    tick();
    check("t1_valid_c2", 64'(bus.m_valid_o), 64'd0);
    check("t1_pop_c2", 64'(bus.ch_pop_o), 64'd0);
    tick();
    check("t1_valid_c3", 64'(bus.m_valid_o), 64'd1);
    check("t1_ch", 64'(bus.m_ch_o), 64'd2);
    check("t1_last", 64'(bus.m_last_o), 64'd1);
    check("t1_data", 64'(bus.m_data_o), 64'(word(2, 0)));
    tick();
    check("t1_valid_after", 64'(bus.m_valid_o), 64'd0);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_pop_count", 64'(pop_cnt[2]), 64'd1);

    // Four full channels after reset: grants 0,1,2,3 repeating, 8-beat bursts.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    beat_log.delete();
    for (int k = 0; k < NUM_CH; k++) push(k, 0, 20);
    wait_beats(80, 1500, "t2_timeout");
    n = 0;
    for (int g = 0; g < 12; g++) begin
      int nb;
      nb = (g < 8) ? 8 : 4;
      for (int b = 0; b < nb; b++) begin
        check_beat("t2_beat", n, g % 4, word(g % 4, (g / 4) * 8 + b), b == nb - 1);
        n++;
      end
    end

    // Short burst: ch1 with 3 words ends early on empty.
    beat_log.delete();
    push(1, 50, 3);
    wait_beats(3, 100, "t3_timeout");
    check_beat("t3_beat0", 0, 1, word(1, 50), 1'b0);
    check_beat("t3_beat1", 1, 1, word(1, 51), 1'b0);
    check_beat("t3_beat2", 2, 1, word(1, 52), 1'b1);
    check("t3_idle", 64'(busy), 64'd0);

    // Backpressure: outputs hold and no pops while ready is low.
    beat_log.delete();
    bus.m_ready_i = 1'b0;
    push(0, 100, 2);
    wait_valid(20, "t4_valid_timeout");
    pops_before = total_pops();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_stall_valid", 64'(bus.m_valid_o), 64'd1);
      check("t4_stall_data", 64'(bus.m_data_o), 64'(word(0, 100)));
      check("t4_stall_ch", 64'(bus.m_ch_o), 64'd0);
      check("t4_stall_last", 64'(bus.m_last_o), 64'd0);
    end
    check("t4_stall_pops", 64'(total_pops()), 64'(pops_before));
    bus.m_ready_i = 1'b1;
    wait_beats(2, 50, "t4_timeout");
    check_beat("t4_beat0", 0, 0, word(0, 100), 1'b0);
    check_beat("t4_beat1", 1, 0, word(0, 101), 1'b1);

    // Reset in SEND of beat 4 on ch3: held word lost, ch0 served first after.
    beat_log.delete();
    push(3, 0, 10);
    tick();
    push(0, 200, 3);
    push(1, 300, 3);
    wait_beats(3, 50, "t5_pre_timeout");
    bus.m_ready_i = 1'b0;
    wait_valid(10, "t5_valid_timeout");
    check("t5_hold_ch", 64'(bus.m_ch_o), 64'd3);
    check("t5_hold_data", 64'(bus.m_data_o), 64'(word(3, 3)));
    rst_i = 1'b1;
    tick();
    check_idle_outputs("t5_reset");
    rst_i = 1'b0;
    bus.m_ready_i = 1'b1;
    beat_log.delete();
    wait_beats(12, 300, "t5_post_timeout");
    check_beat("t5_first", 0, 0, word(0, 200), 1'b0);
    check_beat("t5_ch0_last", 2, 0, word(0, 202), 1'b1);
    check_beat("t5_ch1_first", 3, 1, word(1, 300), 1'b0);
    check_beat("t5_ch3_resume", 6, 3, word(3, 4), 1'b0);
    check_beat("t5_ch3_last", 11, 3, word(3, 9), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
